// File: rtl/adder_operand_stager.sv
// Stages MMIO x/y operand writes as {x, y} pairs in a DEPTH-entry FIFO feeding the adder's valid/ready port.
// Latency 1 cycle from y write to input_valid (0 with ADDER_STAGER_BYPASS_EN); y writes stall on y_wr_ready=0 when full.
`timescale 1ns/1ps

module adder_operand_stager #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       x_wr_en,
    input  logic [WIDTH-1:0]           x_wr_data,
    input  logic                       y_wr_valid,
    output logic                       y_wr_ready,
    input  logic [WIDTH-1:0]           y_wr_data,
    input  logic                       flush,
    output logic                       input_valid,
    input  logic                       input_ready,
    output logic [WIDTH-1:0]           x,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       x_pending,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } pair_t;

    pair_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [WIDTH-1:0]  x_hold;
    logic [WIDTH-1:0]  x_src;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;

    assign empty = (cnt == '0);
    // An x write in the same cycle as the y write is the x that gets paired.
    assign x_src = x_wr_en ? x_wr_data : x_hold;

`ifdef ADDER_STAGER_BYPASS_EN
    assign bypass = empty && y_wr_valid && input_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = y_wr_valid && y_wr_ready && !flush && !bypass;
    assign pop  = !empty && input_ready && !flush;

    always_comb begin
        cnt_next = cnt;
        if (flush)
            cnt_next = '0;
        else if (push && !pop)
            cnt_next = cnt + 1'b1;
        else if (pop && !push)
            cnt_next = cnt - 1'b1;
    end

    always_comb begin
        input_valid = !empty || bypass;
        x           = mem[rd_ptr].x;
        y           = mem[rd_ptr].y;
        if (bypass) begin
            x = x_src;
            y = y_wr_data;
        end
    end

    assign count = cnt;
    assign busy  = !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            x_hold     <= '0;
            x_pending  <= 1'b0;
            y_wr_ready <= 1'b1;
        end else begin
            cnt        <= cnt_next;
            y_wr_ready <= (cnt_next != FULL_CNT);
            if (x_wr_en)
                x_hold <= x_wr_data;
            // A y handshake (stored or bypassed) consumes the pending x, even if x was written that cycle.
            if (flush || push || bypass)
                x_pending <= 1'b0;
            else if (x_wr_en)
                x_pending <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= '{x: x_src, y: y_wr_data};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_operand_stager.sv
// Directed-vector bench for adder_operand_stager (default DEPTH=4, WIDTH=32).
`timescale 1ns/1ps

module tb_adder_operand_stager;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic             x_wr_en;
    logic [WIDTH-1:0] x_wr_data;
    logic             y_wr_valid;
    logic             y_wr_ready;
    logic [WIDTH-1:0] y_wr_data;
    logic             flush;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [$clog2(DEPTH):0] count;
    logic             x_pending;
    logic             busy;

    int n_vec;
    int n_bad;

    adder_operand_stager #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .x_wr_en     (x_wr_en),
        .x_wr_data   (x_wr_data),
        .y_wr_valid  (y_wr_valid),
        .y_wr_ready  (y_wr_ready),
        .y_wr_data   (y_wr_data),
        .flush       (flush),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .x           (x),
        .y           (y),
        .count       (count),
        .x_pending   (x_pending),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        x_wr_en     = 1'b0;
        x_wr_data   = '0;
        y_wr_valid  = 1'b0;
        y_wr_data   = '0;
        flush       = 1'b0;
        input_ready = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_count", 64'(count), 0);
        chk("rst_valid", 64'(input_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_xpend", 64'(x_pending), 0);
        chk("rst_x", 64'(x), 0);
        chk("rst_y", 64'(y), 0);
        chk("rst_yrdy", 64'(y_wr_ready), 1);
        reset = 1'b1;
        tick();

        // Basic pair: x=5, y=7, adder ready
        input_ready = 1'b1;
        x_wr_en = 1'b1; x_wr_data = 5;
        tick();
        x_wr_en = 1'b0;
        y_wr_valid = 1'b1; y_wr_data = 7;
        #1;
        chk("a_xpend_set", 64'(x_pending), 1);
        chk("a_valid_before", 64'(input_valid), 0);
        tick();
        y_wr_valid = 1'b0;
        #1;
        chk("a_valid", 64'(input_valid), 1);
        chk("a_x", 64'(x), 5);
        chk("a_y", 64'(y), 7);
        chk("a_count1", 64'(count), 1);
        chk("a_xpend_clr", 64'(x_pending), 0);
        tick();
        chk("a_count0", 64'(count), 0);
        chk("a_valid0", 64'(input_valid), 0);

        // Fill to full with x=3, stall fifth y, then drain in order
        input_ready = 1'b0;
        x_wr_en = 1'b1; x_wr_data = 3;
        tick();
        x_wr_en = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            y_wr_valid = 1'b1; y_wr_data = WIDTH'(v);
            tick();
        end
        y_wr_data = 5;
        #1;
        chk("b_count_full", 64'(count), 4);
        chk("b_yrdy_full", 64'(y_wr_ready), 0);
        chk("b_busy", 64'(busy), 1);
        tick();
        chk("b_count_stall", 64'(count), 4);
        input_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("b_drain_valid", 64'(input_valid), 1);
            chk("b_drain_x", 64'(x), 3);
            chk("b_drain_y", 64'(y), 64'(k));
            if (k == 1) chk("b_yrdy_k1", 64'(y_wr_ready), 0);
            if (k == 2) chk("b_yrdy_k2", 64'(y_wr_ready), 1);
            tick();
            if (k == 2) y_wr_valid = 1'b0;
        end
        chk("b_count_empty", 64'(count), 0);
        chk("b_valid_empty", 64'(input_valid), 0);

        // Same-cycle x write and y push: write-through x=9
        input_ready = 1'b0;
        y_wr_valid = 1'b1; y_wr_data = 1;
        tick();
        x_wr_en = 1'b1; x_wr_data = 9; y_wr_data = 2;
        tick();
        x_wr_en = 1'b0; y_wr_valid = 1'b0;
        #1;
        chk("c_xpend", 64'(x_pending), 0);
        chk("c_count", 64'(count), 2);
        chk("c_head_y", 64'(y), 1);
        input_ready = 1'b1;
        tick();
        input_ready = 1'b0;
        #1;
        chk("c_pair_x", 64'(x), 9);
        chk("c_pair_y", 64'(y), 2);
        chk("c_count1", 64'(count), 1);
        y_wr_valid = 1'b1; y_wr_data = 10;
        tick();
        y_wr_valid = 1'b0;
        chk("c_count2", 64'(count), 2);

        // Flush with pop and push requested the same cycle
        x_wr_en = 1'b1; x_wr_data = 9;
        tick();
        x_wr_en = 1'b0;
        flush = 1'b1; input_ready = 1'b1; y_wr_valid = 1'b1; y_wr_data = 8;
        tick();
        flush = 1'b0; y_wr_valid = 1'b0;
        chk("d_count", 64'(count), 0);
        chk("d_valid", 64'(input_valid), 0);
        chk("d_xpend", 64'(x_pending), 0);
        tick();
        tick();
        chk("d_valid_later", 64'(input_valid), 0);
        y_wr_valid = 1'b1; y_wr_data = 11;
        tick();
        y_wr_valid = 1'b0;
        #1;
        chk("d_xhold_x", 64'(x), 9);
        chk("d_xhold_y", 64'(y), 11);
        tick();
        chk("d_count_end", 64'(count), 0);

        // Async reset mid-operation with 3 entries queued
        input_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            y_wr_valid = 1'b1; y_wr_data = WIDTH'(v);
            tick();
        end
        y_wr_valid = 1'b0;
        chk("e_count3", 64'(count), 3);
        #2 reset = 1'b0;
        #1;
        chk("e_valid", 64'(input_valid), 0);
        chk("e_busy", 64'(busy), 0);
        chk("e_count", 64'(count), 0);
        chk("e_yrdy", 64'(y_wr_ready), 1);
        #1 reset = 1'b1;
        tick();

        // Empty FIFO, adder ready: bypass or one-cycle path
        input_ready = 1'b1;
        x_wr_en = 1'b1; x_wr_data = 4;
        tick();
        x_wr_en = 1'b0;
        y_wr_valid = 1'b1; y_wr_data = 6;
        #1;
`ifdef ADDER_STAGER_BYPASS_EN
        chk("f_byp_valid", 64'(input_valid), 1);
        chk("f_byp_x", 64'(x), 4);
        chk("f_byp_y", 64'(y), 6);
        chk("f_byp_yrdy", 64'(y_wr_ready), 1);
        tick();
        y_wr_valid = 1'b0;
        #1;
        chk("f_byp_count", 64'(count), 0);
        chk("f_byp_xpend", 64'(x_pending), 0);
        chk("f_byp_valid_after", 64'(input_valid), 0);
`else
        chk("f_valid_same", 64'(input_valid), 0);
        tick();
        y_wr_valid = 1'b0;
        #1;
        chk("f_valid_next", 64'(input_valid), 1);
        chk("f_x", 64'(x), 4);
        chk("f_y", 64'(y), 6);
        chk("f_count", 64'(count), 1);
        tick();
        chk("f_count_end", 64'(count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
